// File: rtl/core_pkg.sv
// Shared writeback types: the CDB packet carried through the load buffer and onto the CDB,
// plus the source encodings used by the arbiter.
package core_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_ROB_W  = 6;

  typedef struct packed {
    logic [CDB_ROB_W-1:0]  rob;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;

  localparam logic CDB_SRC_ALU  = 1'b0;
  localparam logic CDB_SRC_LOAD = 1'b1;

  typedef enum logic {
    GRANT_ALU  = 1'b0,
    GRANT_LOAD = 1'b1
  } grant_e;

  function automatic cdb_pkt_t make_pkt(input logic [CDB_ROB_W-1:0] rob,
                                        input logic [CDB_DATA_W-1:0] data);
    cdb_pkt_t p;
    p.rob  = rob;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of CDB packets. Pointers carry a wrap bit so occupancy is a plain
// pointer difference; a push into a full FIFO is accepted only when a pop frees the head slot.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cdb_pkt_t               din,
  input  logic                   pop,
  output cdb_pkt_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  cdb_pkt_t      mem_q [DEPTH];
  cdb_pkt_t      mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // When full, the write slot is the head slot; the pop reads it this cycle before it is reused.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/load_cdb_arbiter.sv
// Writeback stage behind the load queue: buffers unstallable load completions and merges them
// with ALU results onto a single registered CDB port, alternating fairly unless loads back up.
module load_cdb_arbiter
  import core_pkg::*;
#(
  parameter int DATA_W    = CDB_DATA_W,
  parameter int ROB_W     = CDB_ROB_W,
  parameter int LDB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic [ROB_W-1:0]           ld_rob,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       alu_valid,
  input  logic [ROB_W-1:0]           alu_rob,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  output logic                       cdb_valid,
  output logic [ROB_W-1:0]           cdb_rob,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_src,
  input  logic                       cdb_ready,
  output logic [$clog2(LDB_DEPTH):0] ld_count,
  output logic                       ld_overflow
);

  localparam int CW = $clog2(LDB_DEPTH) + 1;

  cdb_pkt_t fifo_head;
  cdb_pkt_t ld_pkt;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;

  logic     slot_free;
  logic     ld_cand;
  logic     near_full;
  logic     ld_wins;
  logic     grant_ld;
  logic     grant_alu;
  logic     bypass;
  logic     drop;

  logic     cdb_valid_q, cdb_valid_d;
  cdb_pkt_t cdb_pkt_q, cdb_pkt_d;
  logic     cdb_src_q, cdb_src_d;
  grant_e   last_grant_q, last_grant_d;
  logic     ld_overflow_q, ld_overflow_d;

  wb_fifo #(
    .DEPTH (LDB_DEPTH)
  ) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (make_pkt(ld_rob, ld_data)),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ld_count)
  );

  assign slot_free = !cdb_valid_q || cdb_ready;
  assign ld_cand   = !fifo_empty || ld_valid;
  assign near_full = (ld_count >= CW'(LDB_DEPTH - 1));

  // A near-full buffer overrides round-robin so unstallable loads are not lost.
  assign ld_wins   = ld_cand && (!alu_valid || near_full || (last_grant_q == GRANT_ALU));
  assign grant_ld  = slot_free && ld_wins;
  assign grant_alu = slot_free && alu_valid && !ld_wins;
  assign alu_ready = grant_alu;

  assign bypass    = grant_ld && fifo_empty;
  assign fifo_pop  = grant_ld && !fifo_empty;
  assign fifo_push = ld_valid && !bypass;
  assign drop      = fifo_push && fifo_full && !fifo_pop;
  assign ld_pkt    = fifo_empty ? make_pkt(ld_rob, ld_data) : fifo_head;

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_pkt_d     = cdb_pkt_q;
    cdb_src_d     = cdb_src_q;
    last_grant_d  = last_grant_q;
    ld_overflow_d = ld_overflow_q || drop;
    if (grant_ld) begin
      cdb_valid_d  = 1'b1;
      cdb_pkt_d    = ld_pkt;
      cdb_src_d    = CDB_SRC_LOAD;
      last_grant_d = GRANT_LOAD;
    end else if (grant_alu) begin
      cdb_valid_d  = 1'b1;
      cdb_pkt_d    = make_pkt(alu_rob, alu_data);
      cdb_src_d    = CDB_SRC_ALU;
      last_grant_d = GRANT_ALU;
    end else if (slot_free) begin
      cdb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_pkt_q     <= '0;
      cdb_src_q     <= CDB_SRC_ALU;
      last_grant_q  <= GRANT_ALU;
      ld_overflow_q <= 1'b0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_pkt_q     <= cdb_pkt_d;
      cdb_src_q     <= cdb_src_d;
      last_grant_q  <= last_grant_d;
      ld_overflow_q <= ld_overflow_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob     = cdb_pkt_q.rob;
  assign cdb_data    = cdb_pkt_q.data;
  assign cdb_src     = cdb_src_q;
  assign ld_overflow = ld_overflow_q;

endmodule

// File: tb/tb_load_cdb_arbiter.sv
// Directed, table-driven bench for load_cdb_arbiter: vector table for bypass and fair/priority
// arbitration, plus hand-built sequences for overflow, full push+pop, held beats and async reset.
module tb_load_cdb_arbiter;

  localparam logic [31:0] LD_BASE  = 32'h1D00_0000;
  localparam logic [31:0] ALU_BASE = 32'hA1C0_0000;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [5:0]  ld_rob;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic [5:0]  alu_rob;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic        cdb_src;
  logic        cdb_ready;
  logic [2:0]  ld_count;
  logic        ld_overflow;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic        doRst;
    logic        ldV;
    logic [5:0]  ldRob;
    logic [31:0] ldData;
    logic        aluV;
    logic [5:0]  aluRob;
    logic [31:0] aluData;
    logic        rdy;
    logic        expAluRdy;
    logic        expV;
    logic [5:0]  expRob;
    logic [31:0] expData;
    logic        expSrc;
    logic [2:0]  expCnt;
    logic        expOvf;
  } vec_t;

  vec_t tbl[$];

  load_cdb_arbiter #(
    .DATA_W    (32),
    .ROB_W     (6),
    .LDB_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_rob      (ld_rob),
    .ld_data     (ld_data),
    .alu_valid   (alu_valid),
    .alu_rob     (alu_rob),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob     (cdb_rob),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .cdb_ready   (cdb_ready),
    .ld_count    (ld_count),
    .ld_overflow (ld_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ldV, input logic [5:0] ldRob,
                              input logic aluV, input logic [5:0] aluRob,
                              input logic rdy, input logic expAluRdy,
                              input logic expV, input logic [5:0] expRob,
                              input logic expSrc, input logic [2:0] expCnt,
                              input logic expOvf);
    vec_t v;
    v.doRst     = 1'b0;
    v.ldV       = ldV;
    v.ldRob     = ldRob;
    v.ldData    = LD_BASE | 32'(ldRob);
    v.aluV      = aluV;
    v.aluRob    = aluRob;
    v.aluData   = ALU_BASE | 32'(aluRob);
    v.rdy       = rdy;
    v.expAluRdy = expAluRdy;
    v.expV      = expV;
    v.expRob    = expRob;
    v.expData   = (expSrc ? LD_BASE : ALU_BASE) | 32'(expRob);
    v.expSrc    = expSrc;
    v.expCnt    = expCnt;
    v.expOvf    = expOvf;
    return v;
  endfunction

  // Every comparison funnels through here so the summary counts are exact.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ld_valid  = v.ldV;
    ld_rob    = v.ldRob;
    ld_data   = v.ldData;
    alu_valid = v.aluV;
    alu_rob   = v.aluRob;
    alu_data  = v.aluData;
    cdb_ready = v.rdy;
  endtask

  task automatic clearInputs();
    ld_valid  = 1'b0;
    ld_rob    = '0;
    ld_data   = '0;
    alu_valid = 1'b0;
    alu_rob   = '0;
    alu_data  = '0;
    cdb_ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive at the falling edge, check the combinational ready, then the registered result.
  task automatic runCycle(input vec_t v, input string tag);
    if (v.doRst) doReset();
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({tag, ".alu_ready"}, 32'(alu_ready), 32'(v.expAluRdy));
    @(posedge clk);
    #1;
    checkOutput({tag, ".cdb_valid"}, 32'(cdb_valid), 32'(v.expV));
    if (v.expV) begin
      checkOutput({tag, ".cdb_rob"},  32'(cdb_rob), 32'(v.expRob));
      checkOutput({tag, ".cdb_data"}, cdb_data,     v.expData);
      checkOutput({tag, ".cdb_src"},  32'(cdb_src), 32'(v.expSrc));
    end
    checkOutput({tag, ".ld_count"},    32'(ld_count),    32'(v.expCnt));
    checkOutput({tag, ".ld_overflow"}, 32'(ld_overflow), 32'(v.expOvf));
  endtask

  task automatic fillFifo(input int loads, input string tag);
    runCycle(mk(1, 6'd0, 0, 6'd0, 0, 0, 1, 6'd0, 1, 3'd0, 0), {tag, ".fill0"});
    for (int i = 1; i < loads && i <= 4; i++) begin
      runCycle(mk(1, 6'(i), 0, 6'd0, 0, 0, 1, 6'd0, 1, 3'(i), 0), $sformatf("%s.fill%0d", tag, i));
    end
    if (loads > 5) begin
      runCycle(mk(1, 6'd5, 0, 6'd0, 0, 0, 1, 6'd0, 1, 3'd4, 1), {tag, ".drop5"});
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    clearInputs();
    #1;
    checkOutput("reset.cdb_valid",   32'(cdb_valid),   32'd0);
    checkOutput("reset.ld_count",    32'(ld_count),    32'd0);
    checkOutput("reset.ld_overflow", 32'(ld_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bypass: single load with empty buffer goes straight to the CDB.
    v = mk(1, 6'd5, 0, 6'd0, 1, 0, 1, 6'd5, 1, 3'd0, 0);
    v.ldData  = 32'hDEADBEEF;
    v.expData = 32'hDEADBEEF;
    tbl.push_back(v);
    tbl.push_back(mk(0, 6'd0, 0, 6'd0, 1, 0, 0, 6'd0, 0, 3'd0, 0));
    // Fair alternation, then load priority once three loads are buffered.
    v = mk(1, 6'd10, 1, 6'd1, 1, 0, 1, 6'd10, 1, 3'd0, 0);
    v.doRst = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk(1, 6'd11, 1, 6'd1, 1, 1, 1, 6'd1,  0, 3'd1, 0));
    tbl.push_back(mk(1, 6'd12, 1, 6'd2, 1, 0, 1, 6'd11, 1, 3'd1, 0));
    tbl.push_back(mk(1, 6'd13, 1, 6'd2, 1, 1, 1, 6'd2,  0, 3'd2, 0));
    tbl.push_back(mk(1, 6'd14, 1, 6'd3, 1, 0, 1, 6'd12, 1, 3'd2, 0));
    tbl.push_back(mk(1, 6'd15, 1, 6'd3, 1, 1, 1, 6'd3,  0, 3'd3, 0));
    tbl.push_back(mk(1, 6'd16, 1, 6'd4, 1, 0, 1, 6'd13, 1, 3'd3, 0));
    tbl.push_back(mk(1, 6'd17, 1, 6'd4, 1, 0, 1, 6'd14, 1, 3'd3, 0));
    tbl.push_back(mk(1, 6'd18, 1, 6'd4, 1, 0, 1, 6'd15, 1, 3'd3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      runCycle(tbl[i], $sformatf("tbl%0d", i));
    end

    // Overflow with a stalled consumer, then in-order drain.
    doReset();
    fillFifo(6, "ovf");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd1, 1, 3'd3, 1), "ovf.drain1");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd2, 1, 3'd2, 1), "ovf.drain2");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd3, 1, 3'd1, 1), "ovf.drain3");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd4, 1, 3'd0, 1), "ovf.drain4");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 0, 6'd0, 0, 3'd0, 1), "ovf.idle");

    // Full buffer with simultaneous pop accepts the new load without overflow.
    doReset();
    fillFifo(5, "full");
    runCycle(mk(1, 6'd9, 0, 6'd0, 1, 0, 1, 6'd1, 1, 3'd4, 0), "full.pushpop");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd2, 1, 3'd3, 0), "full.drain2");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd3, 1, 3'd2, 0), "full.drain3");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd4, 1, 3'd1, 0), "full.drain4");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 1, 6'd9, 1, 3'd0, 0), "full.drain9");

    // ALU waits behind a held beat and is accepted the same cycle the consumer frees it.
    doReset();
    runCycle(mk(1, 6'd7, 0, 6'd0, 0, 0, 1, 6'd7, 1, 3'd0, 0), "hold.load");
    runCycle(mk(0, 6'd0, 1, 6'd3, 0, 0, 1, 6'd7, 1, 3'd0, 0), "hold.stall");
    runCycle(mk(0, 6'd0, 1, 6'd3, 1, 1, 1, 6'd3, 0, 3'd0, 0), "hold.accept");
    runCycle(mk(0, 6'd0, 0, 6'd0, 1, 0, 0, 6'd0, 0, 3'd0, 0), "hold.idle");

    // Asynchronous reset between edges with loads buffered and a beat on the CDB.
    doReset();
    fillFifo(6, "arst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.cdb_valid",   32'(cdb_valid),   32'd0);
    checkOutput("arst.ld_count",    32'(ld_count),    32'd0);
    checkOutput("arst.ld_overflow", 32'(ld_overflow), 32'd0);
    checkOutput("arst.alu_ready",   32'(alu_ready),   32'd0);
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
